// File: rtl/wb_pkg.sv
// Shared widths, constants and requester indices for the register-file
// write-back arbiter.
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] REG_ZR = 5'd31;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

  // Writes to the zero register are accepted but never reach the file.
  function automatic logic is_zr(input logic [ADDR_W-1:0] addr);
    return addr == REG_ZR;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// priority bit that points at the requester not granted last.
module rr_arbiter2
  import wb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  req_idx_e pri;

  always_comb begin
    gnt = 2'b00;
    // Reset gates grants so no transfer can be seen while reset is high.
    if (!hold && !reset) begin
      if (req[REQ_ALU] && req[REQ_MEM]) begin
        if (pri == REQ_ALU) gnt[REQ_ALU] = 1'b1;
        else                gnt[REQ_MEM] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pri <= REQ_ALU;
    end else if (gnt[REQ_ALU]) begin
      pri <= REQ_MEM;
    end else if (gnt[REQ_MEM]) begin
      pri <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU and load write-back requests
// onto one registered write port. Optional read bypass: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              wb_hold,
  output logic              W,
  output logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] D,
  output logic [CNT_W-1:0]  conflict_cnt,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic [DATA_W-1:0] A_rf,
  input  logic [DATA_W-1:0] B_rf,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  logic [1:0]        gnt;
  logic              fire;
  logic              wr;
  logic              contend;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({mem_valid, alu_valid}),
    .hold  (wb_hold),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign mem_ready = gnt[REQ_MEM];

  always_comb begin
    sel_addr = alu_addr;
    sel_data = alu_data;
    if (gnt[REQ_MEM]) begin
      sel_addr = mem_addr;
      sel_data = mem_data;
    end
  end

  assign fire    = |gnt;
  assign wr      = fire && !is_zr(sel_addr);
  assign contend = alu_valid && mem_valid && !wb_hold;

  // DA/D keep their last value on idle cycles and zero-register transfers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      W  <= 1'b0;
      DA <= '0;
      D  <= '0;
    end else begin
      W <= wr;
      if (wr) begin
        DA <= sel_addr;
        D  <= sel_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (contend && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    A = A_rf;
    B = B_rf;
    if (W && (DA == SA) && !is_zr(SA)) A = D;
    if (W && (DA == SB) && !is_zr(SB)) B = D;
  end
`else
  logic unused_sel;

  assign unused_sel = ^{SA, SB};
  assign A = A_rf;
  assign B = B_rf;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports: clock in 1, posedge clock for all state; one clock only.
REQ-002 SHALL have reset in 1: asynchronous, active-high.
REQ-003 SHALL have alu_valid in 1, alu_addr in 5, alu_data in 64 and alu_ready out 1: ALU write-back request channel.
REQ-004 SHALL have mem_valid in 1, mem_addr in 5, mem_data in 64 and mem_ready out 1: load write-back request channel.
REQ-005 SHALL have wb_hold in 1: when high, no request is accepted.
REQ-006 SHALL have W out 1, DA out 5 and D out 64, all registered, driving the register-file write port.
REQ-007 SHALL have conflict_cnt out 16: saturating count of contention cycles.
REQ-008 SHALL have SA in 5, SB in 5, A_rf in 64, B_rf in 64, A out 64 and B out 64: read path, present in both builds.

Function
REQ-009 SHALL accept at most one request per cycle; transfer = valid && ready at a clock posedge.
REQ-010 SHALL drive alu_ready/mem_ready combinationally, each asserted only with its own valid, never both, and neither while wb_hold=1.
REQ-011 SHALL use 1-bit round-robin priority pri, 0 = ALU favoured, when both are valid; after any transfer pri points to the non-granted requester.
REQ-012 SHALL grant a lone valid requester regardless of pri, and SHALL then still update pri.
REQ-013 SHALL drive W=1 with DA/D = accepted addr/data for exactly the cycle after the transfer edge (latency 1); W=0 otherwise.
REQ-014 SHALL accept a transfer to addr 31 (XZR) with ready high, SHALL leave W=0 for it, and SHALL hold DA/D.
REQ-015 SHALL, when both requesters are valid with the same addr, write the winner first and the loser next, so the loser's data remains in the register.
REQ-016 SHALL, while valid is high and ready is low, require the requester to hold addr/data stable; the block never drops a request.
REQ-017 SHALL increment conflict_cnt by 1 in each cycle with alu_valid && mem_valid && !wb_hold, saturating at 16'hFFFF.
REQ-018 SHALL, when wb_hold rises, still perform any write already registered on W; no new transfers are accepted.

Reset
REQ-019 SHALL, while reset=1, immediately force W=0, DA=0, D=0, pri=0 and conflict_cnt=0.
REQ-020 SHALL, on reset asserted mid-operation, discard the pending registered write without any register-file write; ready outputs are 0 while reset=1.

Configuration
REQ-021 SHALL compile bypass logic only when macro REGFILE_WB_BYPASS_EN is defined.
REQ-022 SHALL, with REGFILE_WB_BYPASS_EN, set A=D when W=1 && DA==SA && SA!=31, else A=A_rf; B likewise with SB and B_rf.
REQ-023 SHALL, without REGFILE_WB_BYPASS_EN, set A=A_rf and B=B_rf combinationally, and SHALL leave SA/SB unused.

Structure
REQ-024 SHALL take from shared package wb_pkg: ADDR_W=5, DATA_W=64, REG_ZR=5'd31, CNT_W=16, and a requester-index enum REQ_ALU=0, REQ_MEM=1.
REQ-025 SHALL place grant and priority logic in one sub-module rr_arbiter2: 2 requests, hold input, 2 one-hot grants, internal pri flop.
REQ-026 SHALL keep the output register, counter and bypass muxes in the top level.

Verification
REQ-027 SHALL test a single ALU write: alu_valid, addr=3, data=64'h1234 for one cycle -> alu_ready=1 that cycle; next cycle W=1, DA=3, D=64'h1234; the following cycle W=0.
REQ-028 SHALL test contention: both valid for 4 cycles from reset, addr 1 (ALU) and 2 (MEM) -> grants ALU, MEM, ALU, MEM; conflict_cnt=4 afterwards.
REQ-029 SHALL test XZR: mem_valid, addr=31, data=all-ones -> mem_ready=1; W stays 0; DA/D unchanged.
REQ-030 SHALL test same-address ordering: both target addr 5 (ALU 64'hA, MEM 64'hB) with pri=0 -> W cycles write A then B; the register file holds 64'hB.
REQ-031 SHALL test hold and reset: wb_hold=1 with both valid -> no ready and no W; then reset pulse mid-transfer -> W, DA, D, conflict_cnt all 0 immediately; first grant after reset goes to ALU.
REQ-032 SHALL test bypass with the macro defined: W=1, DA=7, D=64'h55, SA=7, A_rf=0 -> A=64'h55; without the macro -> A=0.
